// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WB    = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   // pc_in holds this value only before the first PC load after reset
   localparam logic [31:0] PC_SENTINEL          = 32'hFFFF_FFFF;
   localparam logic [31:0] INSTR_BYTES          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   function automatic logic [31:0] select_fetch_addr(input logic [31:0] pc,
                                                     input logic [31:0] reset_vector);
      return (pc == PC_SENTINEL) ? reset_vector : pc;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timeout_ctr
// Description : 8-bit wait-cycle counter; flags the last permitted wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // expired fires during the TIMEOUT-th counted cycle so the FSM leaves on that edge
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == LAST_WAIT);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch FSM with flush and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] pc_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [31:0] new_pc,
   output logic        pc_write,
   output logic        done,
   output logic        busy,
   output logic        fault
);

   fetch_state_t state_q, state_d;
   logic         mem_req_q, mem_req_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  new_pc_q, new_pc_d;
   logic         pc_write_q, pc_write_d;
   logic         done_q, done_d;
   logic         busy_q, busy_d;
   logic         fault_q, fault_d;

   logic         ctr_clear;
   logic         ctr_enable;
   logic         ctr_expired;
   logic [31:0]  fetch_addr;

   fetch_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst     (rst),
      .clear   (ctr_clear),
      .enable  (ctr_enable),
      .expired (ctr_expired)
   );

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      ir_d       = ir_q;
      new_pc_d   = new_pc_q;
      pc_write_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;
      fault_d    = fault_q;
      ctr_clear  = 1'b0;
      ctr_enable = 1'b0;
      fetch_addr = select_fetch_addr(pc_in, RESET_VECTOR);

      case (state_q)
         ST_IDLE: begin
            // flush outranks a simultaneous start
            if (start && !flush) begin
               busy_d = 1'b1;
               if (is_misaligned(fetch_addr)) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d    = ST_REQ;
                  mem_req_d  = 1'b1;
                  mem_addr_d = fetch_addr;
                  ctr_clear  = 1'b1;
               end
            end
         end

         ST_REQ: begin
            ctr_enable = !flush && !mem_ack;
            if (flush) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               busy_d    = 1'b0;
            end else if (mem_ack) begin
               state_d    = ST_WB;
               mem_req_d  = 1'b0;
               ir_d       = mem_rdata;
               new_pc_d   = mem_addr_q + INSTR_BYTES;
               pc_write_d = 1'b1;
               done_d     = 1'b1;
            end else if (ctr_expired) begin
               state_d   = ST_FAULT;
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
            end
         end

         ST_WB: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         ST_FAULT: begin
            state_d = ST_FAULT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'd0;
         ir_q       <= 32'd0;
         new_pc_q   <= 32'd0;
         pc_write_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         ir_q       <= ir_d;
         new_pc_q   <= new_pc_d;
         pc_write_q <= pc_write_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         fault_q    <= fault_d;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign ir       = ir_q;
   assign new_pc   = new_pc_q;
   assign pc_write = pc_write_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Vector table, directed corner sequences and random model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam int          TO = 4;
   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, start, flush, mem_ack;
   logic [31:0] pc_in, mem_rdata;
   logic        mem_req, pc_write, done, busy, fault;
   logic [31:0] mem_addr, ir, new_pc;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_VECTOR (RV),
      .TIMEOUT      (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .flush     (flush),
      .pc_in     (pc_in),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .new_pc    (new_pc),
      .pc_write  (pc_write),
      .done      (done),
      .busy      (busy),
      .fault     (fault)
   );

   typedef logic [100:0] obs_t;

   typedef struct {
      logic        rst;
      logic        start;
      logic        flush;
      logic [31:0] pc;
      logic        ack;
      logic [31:0] rdata;
      obs_t        exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vt[$];

   // reference model state
   bit          m_in_req, m_wb, m_flt;
   int          m_wait;
   logic [31:0] m_addr, m_ir, m_npc;

   function automatic obs_t o(logic rq, logic [31:0] ad, logic [31:0] iv, logic [31:0] np,
                              logic pw, logic dn, logic bs, logic ft);
      return {rq, ad, iv, np, pw, dn, bs, ft};
   endfunction

   function automatic obs_t observed();
      return {mem_req, mem_addr, ir, new_pc, pc_write, done, busy, fault};
   endfunction

   function automatic vec_t v(logic r, logic s, logic f, logic [31:0] p, logic a,
                              logic [31:0] d, obs_t e);
      vec_t t;
      t.rst = r; t.start = s; t.flush = f; t.pc = p; t.ack = a; t.rdata = d; t.exp = e;
      return t;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got req=%0b addr=%h ir=%h npc=%h pw=%0b done=%0b busy=%0b fault=%0b, expected req=%0b addr=%h ir=%h npc=%h pw=%0b done=%0b busy=%0b fault=%0b",
                  name, got[100], got[99:68], got[67:36], got[35:4], got[3], got[2], got[1], got[0],
                  exp[100], exp[99:68], exp[67:36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic apply(input logic r, input logic s, input logic f, input logic [31:0] p,
                        input logic a, input logic [31:0] d);
      rst = r; start = s; flush = f; pc_in = p; mem_ack = a; mem_rdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic r, input logic s, input logic f, input logic [31:0] p,
                        input logic a, input logic [31:0] d);
      logic [31:0] fa;
      if (r) begin
         m_in_req = 0; m_wb = 0; m_flt = 0; m_wait = 0;
         m_addr = 0; m_ir = 0; m_npc = 0;
      end else if (m_flt) begin
         // terminal
      end else if (m_wb) begin
         m_wb = 0;
      end else if (m_in_req) begin
         if (f) begin
            m_in_req = 0;
         end else if (a) begin
            m_ir = d; m_npc = m_addr + 32'd4; m_in_req = 0; m_wb = 1;
         end else begin
            m_wait++;
            if (m_wait >= TO) begin
               m_in_req = 0; m_flt = 1;
            end
         end
      end else if (s && !f) begin
         fa = (p == 32'hFFFF_FFFF) ? RV : p;
         if (fa % 4 != 0) m_flt = 1;
         else begin
            m_in_req = 1; m_addr = fa; m_wait = 0;
         end
      end
   endtask

   function automatic obs_t model_obs();
      return o(m_in_req, m_addr, m_ir, m_npc, m_wb, m_wb, m_in_req | m_wb | m_flt, m_flt);
   endfunction

   initial begin
      rst = 1; start = 0; flush = 0; pc_in = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;

      // reset vector fetch with zero-wait memory
      vt.push_back(v(1,0,0,32'h0,0,32'h0,         o(0,32'h0,32'h0,32'h0,0,0,0,0)));
      vt.push_back(v(0,1,0,32'hFFFF_FFFF,0,32'h0, o(1,32'h0,32'h0,32'h0,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,1,32'h2002_0005, o(0,32'h0,32'h2002_0005,32'h4,1,1,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(0,32'h0,32'h2002_0005,32'h4,0,0,0,0)));
      // three wait states at 0x40
      vt.push_back(v(0,1,0,32'h40,0,32'h0,        o(1,32'h40,32'h2002_0005,32'h4,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(1,32'h40,32'h2002_0005,32'h4,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(1,32'h40,32'h2002_0005,32'h4,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(1,32'h40,32'h2002_0005,32'h4,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,1,32'hAABB_CCDD, o(0,32'h40,32'hAABB_CCDD,32'h44,1,1,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(0,32'h40,32'hAABB_CCDD,32'h44,0,0,0,0)));
      // wraparound, start while busy, flush in WB
      vt.push_back(v(0,1,0,32'hFFFF_FFFC,0,32'h0, o(1,32'hFFFF_FFFC,32'hAABB_CCDD,32'h44,0,0,1,0)));
      vt.push_back(v(0,1,0,32'h100,0,32'h0,       o(1,32'hFFFF_FFFC,32'hAABB_CCDD,32'h44,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,1,32'h1234_5678, o(0,32'hFFFF_FFFC,32'h1234_5678,32'h0,1,1,1,0)));
      vt.push_back(v(0,0,1,32'h0,0,32'h0,         o(0,32'hFFFF_FFFC,32'h1234_5678,32'h0,0,0,0,0)));
      // flush together with ack, flush+start in idle, stray ack, then normal fetch
      vt.push_back(v(0,1,0,32'h80,0,32'h0,        o(1,32'h80,32'h1234_5678,32'h0,0,0,1,0)));
      vt.push_back(v(0,0,1,32'h0,1,32'hDEAD_BEEF, o(0,32'h80,32'h1234_5678,32'h0,0,0,0,0)));
      vt.push_back(v(0,1,1,32'h90,0,32'h0,        o(0,32'h80,32'h1234_5678,32'h0,0,0,0,0)));
      vt.push_back(v(0,0,0,32'h0,1,32'h55,        o(0,32'h80,32'h1234_5678,32'h0,0,0,0,0)));
      vt.push_back(v(0,1,0,32'h90,0,32'h0,        o(1,32'h90,32'h1234_5678,32'h0,0,0,1,0)));
      vt.push_back(v(0,0,0,32'h0,1,32'h0BAD_F00D, o(0,32'h90,32'h0BAD_F00D,32'h94,1,1,1,0)));
      vt.push_back(v(0,0,0,32'h0,0,32'h0,         o(0,32'h90,32'h0BAD_F00D,32'h94,0,0,0,0)));
      // misaligned address faults without requesting
      vt.push_back(v(0,1,0,32'h42,0,32'h0,        o(0,32'h90,32'h0BAD_F00D,32'h94,0,0,1,1)));
      vt.push_back(v(0,1,0,32'h40,0,32'h0,        o(0,32'h90,32'h0BAD_F00D,32'h94,0,0,1,1)));
      vt.push_back(v(0,0,0,32'h0,1,32'h77,        o(0,32'h90,32'h0BAD_F00D,32'h94,0,0,1,1)));
      vt.push_back(v(1,0,0,32'h0,0,32'h0,         o(0,32'h0,32'h0,32'h0,0,0,0,0)));

      for (int i = 0; i < vt.size(); i++) begin
         apply(vt[i].rst, vt[i].start, vt[i].flush, vt[i].pc, vt[i].ack, vt[i].rdata);
         check($sformatf("vec%0d", i), observed(), vt[i].exp);
      end

      // timeout: four unanswered request cycles, then sticky fault
      apply(0,1,0,32'h200,0,32'h0);
      check("to_req_c1", observed(), o(1,32'h200,32'h0,32'h0,0,0,1,0));
      for (int k = 2; k <= TO; k++) begin
         apply(0,0,0,32'h0,0,32'h0);
         check($sformatf("to_req_c%0d", k), observed(), o(1,32'h200,32'h0,32'h0,0,0,1,0));
      end
      apply(0,0,0,32'h0,0,32'h0);
      check("to_fault", observed(), o(0,32'h200,32'h0,32'h0,0,0,1,1));
      apply(0,1,0,32'h10,0,32'h0);
      apply(0,0,1,32'h0,1,32'h99);
      check("to_sticky", observed(), o(0,32'h200,32'h0,32'h0,0,0,1,1));
      apply(1,0,0,32'h0,0,32'h0);
      check("to_rst_clear", observed(), o(0,32'h0,32'h0,32'h0,0,0,0,0));

      // reset during request, then a late ack
      apply(0,1,0,32'h300,0,32'h0);
      check("rr_req", observed(), o(1,32'h300,32'h0,32'h0,0,0,1,0));
      apply(1,1,1,32'h0,1,32'h1111_2222);
      check("rr_rst", observed(), o(0,32'h0,32'h0,32'h0,0,0,0,0));
      apply(0,0,0,32'h0,1,32'hCAFE_0001);
      check("rr_late_ack", observed(), o(0,32'h0,32'h0,32'h0,0,0,0,0));
      apply(0,0,0,32'h0,0,32'h0);
      check("rr_idle", observed(), o(0,32'h0,32'h0,32'h0,0,0,0,0));

      // randomized traffic against the reference model
      model(1,0,0,32'h0,0,32'h0);
      apply(1,0,0,32'h0,0,32'h0);
      check("rand_rst", observed(), model_obs());
      for (int i = 0; i < 3000; i++) begin
         logic        r, s, f, a;
         logic [31:0] p, d;
         int          sel;
         r   = (m_flt && ($urandom_range(7) == 0)) || ($urandom_range(99) == 0);
         s   = ($urandom_range(3) == 0);
         f   = ($urandom_range(9) == 0);
         a   = ($urandom_range(2) == 0);
         d   = $urandom;
         sel = $urandom_range(15);
         p   = {$urandom, 2'b00} >> 2 << 2;
         if (sel == 0)      p = 32'hFFFF_FFFF;
         else if (sel == 1) p = 32'hFFFF_FFFC;
         else if (sel == 2) p = $urandom | 32'h1;
         else if (sel == 3) p = {$urandom_range(255), 2'b10};
         model(r, s, f, p, a, d);
         apply(r, s, f, p, a, d);
         check("random", observed(), model_obs());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the fetch address used when pc_in holds the post-reset sentinel.
REQ-002 Parameter TIMEOUT, default 255, is the maximum cycles spent waiting for mem_ack before faulting; legal range 1..255.
REQ-003 Ports, in order:
 clk        in   1   clock, rising edge
 rst        in   1   reset, synchronous, active-high
 start      in   1   one-cycle pulse from control FSM requesting an instruction fetch
 flush      in   1   abort any outstanding fetch
 pc_in      in   32  current program counter
 mem_req    out  1   memory read request, level
 mem_addr   out  32  read address, word-aligned
 mem_ack    in   1   memory read data valid, single cycle
 mem_rdata  in   32  memory read data
 ir         out  32  instruction register
 new_pc     out  32  next sequential PC (fetch address + 4)
 pc_write   out  1   one-cycle strobe: PC register loads new_pc
 done       out  1   one-cycle strobe: ir updated
 busy       out  1   high in any state except IDLE
 fault      out  1   sticky error flag

Function
REQ-004 The FSM shall have states IDLE, REQ, WB and FAULT.
REQ-005 In IDLE, start=1 shall capture the fetch address: RESET_VECTOR if pc_in==32'hFFFF_FFFF, else pc_in.
REQ-006 If the captured address has non-zero bits [1:0], the FSM shall go IDLE->FAULT and mem_req shall never assert.
REQ-007 Otherwise the FSM shall go IDLE->REQ; mem_req=1 and mem_addr=fetch address from the next cycle onward.
REQ-008 mem_addr shall remain stable while mem_req=1.
REQ-009 In REQ, mem_ack=1 shall load ir<=mem_rdata, new_pc<=mem_addr+4, and move to WB; mem_req shall deassert on the same edge.
REQ-010 In WB, pc_write=1 and done=1 shall assert for exactly one cycle, then the FSM shall return to IDLE.
REQ-011 Latency: start at cycle 0 with mem_ack at cycle k (k>=1) shall give done/pc_write at cycle k+1; zero-wait memory gives done at cycle 2.
REQ-012 new_pc arithmetic shall be modulo 2^32: fetch address 32'hFFFF_FFFC yields new_pc 32'h0000_0000.
REQ-013 start while busy=1 shall be ignored.
REQ-014 flush=1 in REQ shall return to IDLE on the next edge and drop mem_req; ir and new_pc shall be unchanged, and pc_write/done shall not assert.
REQ-015 flush and mem_ack in the same cycle: flush wins and the data is discarded.
REQ-016 flush in IDLE or WB shall have no effect; flush and start together in IDLE: flush wins.
REQ-017 A wait counter shall clear on entry to REQ and increment each REQ cycle without mem_ack; when it reaches TIMEOUT, the FSM shall go to FAULT and drop mem_req.
REQ-018 FAULT shall be terminal: fault=1 and busy=1, all requests ignored, exit only by rst.
REQ-019 mem_ack outside REQ shall be ignored.

Reset
REQ-020 On rst=1 at a clock edge, the FSM shall enter IDLE and outputs shall take: mem_req=0, mem_addr=0, ir=0, new_pc=0, pc_write=0, done=0, busy=0, fault=0; the wait counter shall clear.
REQ-021 rst during REQ shall drop mem_req on that edge; a mem_ack arriving afterwards shall be ignored.
REQ-022 rst shall take priority over start, flush and mem_ack.

Structure
REQ-023 Package fetch_pkg shall hold the state enum, PC_SENTINEL=32'hFFFF_FFFF, INSTR_BYTES=4 and the default RESET_VECTOR.
REQ-024 The wait counter shall be a sub-module named fetch_timeout_ctr (inputs clear and enable, 8-bit count, output expired).

Verification
REQ-025 Reset, then start with pc_in=32'hFFFF_FFFF, memory acks at cycle 1 with 32'h2002_0005 -> mem_addr=0, ir=32'h2002_0005, new_pc=4, pc_write and done at cycle 2.
REQ-026 pc_in=32'h0000_0040 with 3 wait cycles -> mem_req held for 4 cycles at addr 0x40, done at cycle 5, new_pc=0x44.
REQ-027 pc_in=32'hFFFF_FFFC -> new_pc=0x0000_0000; pc_in=32'h0000_0042 -> fault=1, mem_req never asserted.
REQ-028 flush asserted together with mem_ack -> ir unchanged, no pc_write, busy=0 next cycle; a subsequent start works normally.
REQ-029 TIMEOUT=4 and mem_ack never asserted -> fault=1 after 4 REQ cycles, mem_req=0; only rst clears fault.
REQ-030 rst asserted in REQ, then a late mem_ack -> all outputs at reset values, ir stays 0.
